// File: rtl/tap_coincidence_counter_pkg.sv
//------------------------------------------------------------------------------
// Module  : etch_tap_pkg
// Brief   : Shared types, default sizes and the saturating/wrapping add used
//           by every counter of the tap coincidence counter.
// Macro   : TAP_CNT_SAT_EN - counters saturate at 2^CNT_W-1 instead of wrapping
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

package etch_tap_pkg;

   // Window FSM: IDLE has seen no sample of the open window, ACCUM has.
   typedef enum logic [0:0] {
      ST_IDLE  = 1'b0,
      ST_ACCUM = 1'b1
   } tap_state_t;

   localparam int TAP_WINDOW_DEF = 16;
   localparam int TAP_CNT_W_DEF  = 8;

   // Adds a single-bit increment to a width-bit count held in a 32-bit
   // container. Width is limited to 31 so the raw sum never overflows the
   // container; the result is either clamped or wrapped to width bits.
   function automatic logic [31:0] tap_acc_add(input logic [31:0]   acc,
                                               input logic          inc,
                                               input int unsigned   width);
      logic [31:0] sum;
      logic [31:0] max_val;
      max_val = (32'd1 << width) - 32'd1;
      sum     = acc + {31'd0, inc};
`ifdef TAP_CNT_SAT_EN
      if (sum > max_val) begin
         sum = max_val;
      end
`endif
      return sum & max_val;
   endfunction

endpackage

`default_nettype wire

// File: rtl/tap_coincidence_counter_window.sv
//------------------------------------------------------------------------------
// Module  : tap_window_counter
// Brief   : Sample counter of the open window. Counts accepted samples,
//           raises win_close when the WINDOW-th sample arrives or a qualified
//           flush is seen, and reports the window length including the
//           current sample.
// Macro   : TAP_CNT_SAT_EN - reported length saturates at 2^CNT_W-1
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tap_window_counter
   import etch_tap_pkg::*;
#(
   parameter int WINDOW = TAP_WINDOW_DEF,
   parameter int CNT_W  = TAP_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush_ok,
   output logic             win_close,
   output logic [CNT_W-1:0] win_len
);

   // The stored count never reaches WINDOW (it clears on that edge), so
   // CNT_W bits suffice even for WINDOW = 2^CNT_W; the compare needs one more.
   logic [CNT_W-1:0] smp_cnt_q;
   logic [CNT_W-1:0] smp_cnt_d;
   logic [CNT_W:0]   smp_nxt;

   // Next count, close detection and reported length
   always_comb begin
      smp_nxt   = {1'b0, smp_cnt_q} + {{CNT_W{1'b0}}, en};
      win_close = (en && (smp_nxt == (CNT_W+1)'(WINDOW))) || flush_ok;
      win_len   = CNT_W'(tap_acc_add(32'(smp_cnt_q), en, 32'(CNT_W)));
      smp_cnt_d = win_close ? '0 : smp_nxt[CNT_W-1:0];
   end

   // Sample counter register
   always_ff @(posedge clk) begin
      if (rst) begin
         smp_cnt_q <= '0;
      end else begin
         smp_cnt_q <= smp_cnt_d;
      end
   end

endmodule

`default_nettype wire

// File: rtl/tap_coincidence_counter.sv
//------------------------------------------------------------------------------
// Module  : tap_coincidence_counter
// Brief   : Counts agree-high (both taps 1) and disagree samples of the two
//           shifter taps over windows of WINDOW accepted samples and publishes
//           both counts plus the window length with a one-cycle valid pulse.
// Macro   : TAP_CNT_SAT_EN - accumulators and length saturate at 2^CNT_W-1
// Rev     : 1.0 - initial release
//------------------------------------------------------------------------------
`default_nettype none

module tap_coincidence_counter
   import etch_tap_pkg::*;
#(
   parameter int WINDOW = TAP_WINDOW_DEF,
   parameter int CNT_W  = TAP_CNT_W_DEF
) (
   input  logic             clk,
   input  logic             rst,
   input  logic             en,
   input  logic             flush,
   input  logic             in1,
   input  logic             in2,
   output logic [CNT_W-1:0] both_cnt,
   output logic [CNT_W-1:0] diff_cnt,
   output logic [CNT_W-1:0] win_len,
   output logic             cnt_valid
);

   tap_state_t       state_q;
   tap_state_t       state_d;
   logic             flush_ok;
   logic             win_close;
   logic [CNT_W-1:0] len_now;

   logic [CNT_W-1:0] both_acc_q;
   logic [CNT_W-1:0] both_acc_d;
   logic [CNT_W-1:0] diff_acc_q;
   logic [CNT_W-1:0] diff_acc_d;
   logic [CNT_W-1:0] both_sum;
   logic [CNT_W-1:0] diff_sum;

   logic [CNT_W-1:0] both_cnt_q;
   logic [CNT_W-1:0] both_cnt_d;
   logic [CNT_W-1:0] diff_cnt_q;
   logic [CNT_W-1:0] diff_cnt_d;
   logic [CNT_W-1:0] win_len_q;
   logic [CNT_W-1:0] win_len_d;
   logic             cnt_valid_q;
   logic             cnt_valid_d;

   tap_window_counter #(
      .WINDOW (WINDOW),
      .CNT_W  (CNT_W)
   ) u_window (
      .clk       (clk),
      .rst       (rst),
      .en        (en),
      .flush_ok  (flush_ok),
      .win_close (win_close),
      .win_len   (len_now)
   );

   // FSM state register
   always_ff @(posedge clk) begin
      if (rst) begin
         state_q <= ST_IDLE;
      end else begin
         state_q <= state_d;
      end
   end

   // FSM next state: a close always returns to IDLE; the next accepted
   // sample re-enters ACCUM without any gap cycle
   always_comb begin
      state_d = state_q;
      case (state_q)
         ST_IDLE:  if (en && !win_close) state_d = ST_ACCUM;
         ST_ACCUM: if (win_close)        state_d = ST_IDLE;
         default:                        state_d = ST_IDLE;
      endcase
   end

   // FSM output: flush only closes a window that holds at least one sample
   always_comb begin
      flush_ok = 1'b0;
      case (state_q)
         ST_IDLE:  flush_ok = flush && en;
         ST_ACCUM: flush_ok = flush;
         default:  flush_ok = 1'b0;
      endcase
   end

   // Accumulate the current sample and capture results on a close
   always_comb begin
      both_sum    = CNT_W'(tap_acc_add(32'(both_acc_q), en & in1 & in2, 32'(CNT_W)));
      diff_sum    = CNT_W'(tap_acc_add(32'(diff_acc_q), en & (in1 ^ in2), 32'(CNT_W)));
      both_acc_d  = win_close ? '0 : both_sum;
      diff_acc_d  = win_close ? '0 : diff_sum;
      both_cnt_d  = win_close ? both_sum : both_cnt_q;
      diff_cnt_d  = win_close ? diff_sum : diff_cnt_q;
      win_len_d   = win_close ? len_now  : win_len_q;
      cnt_valid_d = win_close;
   end

   // Accumulator and output registers
   always_ff @(posedge clk) begin
      if (rst) begin
         both_acc_q  <= '0;
         diff_acc_q  <= '0;
         both_cnt_q  <= '0;
         diff_cnt_q  <= '0;
         win_len_q   <= '0;
         cnt_valid_q <= 1'b0;
      end else begin
         both_acc_q  <= both_acc_d;
         diff_acc_q  <= diff_acc_d;
         both_cnt_q  <= both_cnt_d;
         diff_cnt_q  <= diff_cnt_d;
         win_len_q   <= win_len_d;
         cnt_valid_q <= cnt_valid_d;
      end
   end

   assign both_cnt  = both_cnt_q;
   assign diff_cnt  = diff_cnt_q;
   assign win_len   = win_len_q;
   assign cnt_valid = cnt_valid_q;

endmodule

`default_nettype wire
